// File: rtl/frame_packer.sv
// Packs four 128-bit input beats into one 512-bit word and emits a frame of
// WORDS_PER_FRAME words, then stalls input for DRAIN_CYCLES so the downstream stage can finish.
module frame_packer #(
    parameter int DRAIN_CYCLES    = 65,
    parameter int WORDS_PER_FRAME = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] out_data,
    output logic         out_valid,
    output logic         frame_done,
    output logic [5:0]   word_cnt
);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [5:0] LAST_WORD  = 6'(WORDS_PER_FRAME - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);

    logic [0:0]   state;
    logic [1:0]   beat_cnt;
    logic [7:0]   drain_cnt;
    logic [383:0] staging;
    logic         accept;
    logic         word_complete;
    logic         frame_complete;

    // Ready depends only on registered state so the source never sees a combinational path.
    assign in_ready       = (state == FILL);
    assign accept         = in_valid && in_ready;
    assign word_complete  = accept && (beat_cnt == 2'd3);
    assign frame_complete = word_complete && (word_cnt == LAST_WORD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            beat_cnt <= 2'd0;
            staging  <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 2'd1;
            case (beat_cnt)
                2'd0:    staging[127:0]   <= in_data;
                2'd1:    staging[255:128] <= in_data;
                2'd2:    staging[383:256] <= in_data;
                default: staging          <= staging;
            endcase
        end
    end

    // The fourth beat bypasses staging and goes straight into the emitted word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            word_cnt   <= 6'd0;
        end else begin
            out_valid  <= word_complete;
            frame_done <= frame_complete;
            if (word_complete) begin
                out_data <= {in_data, staging};
                word_cnt <= frame_complete ? 6'd0 : word_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= FILL;
            drain_cnt <= 8'd0;
        end else begin
            case (state)
                FILL: begin
                    if (frame_complete) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                default: begin
                    if (drain_cnt <= 8'd1) begin
                        state     <= FILL;
                        drain_cnt <= 8'd0;
                    end else begin
                        drain_cnt <= drain_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// Self-checking bench for frame_packer: randomized beats compared every cycle against a
// queue-based model of beats, words per frame and drain time.
module tb_frame_packer;

    localparam int DRAIN = 65;
    localparam int WPF   = 64;

    logic         CLK = 1'b0;
    logic         RST;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] out_data;
    logic         out_valid;
    logic         frame_done;
    logic [5:0]   word_cnt;

    int checks = 0;
    int errors = 0;

    logic [127:0] beat_q[$];
    int           words_in_frame;
    int           drain_left;
    int           accepted;
    logic         exp_valid;
    logic         exp_done;
    logic         exp_ready;
    logic [511:0] exp_data;
    logic [5:0]   exp_wcnt;

    frame_packer #(.DRAIN_CYCLES(DRAIN), .WORDS_PER_FRAME(WPF)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done), .word_cnt(word_cnt)
    );

    always #5 CLK = ~CLK;

    // One clock of the reference model: inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        logic acc;
        acc = in_valid && exp_ready;
        @(posedge CLK);
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (drain_left > 0) begin
            drain_left--;
        end else if (acc) begin
            beat_q.push_back(in_data);
            accepted++;
            if (beat_q.size() == 4) begin
                exp_data = {beat_q[3], beat_q[2], beat_q[1], beat_q[0]};
                beat_q.delete();
                exp_valid = 1'b1;
                words_in_frame++;
                if (words_in_frame == WPF) begin
                    exp_done       = 1'b1;
                    words_in_frame = 0;
                    drain_left     = DRAIN;
                end
            end
        end
        exp_wcnt  = 6'(words_in_frame);
        exp_ready = (drain_left == 0);
        #1;
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        beat_q.delete();
        words_in_frame = 0;
        drain_left     = 0;
        accepted       = 0;
        exp_valid      = 1'b0;
        exp_done       = 1'b0;
        exp_ready      = 1'b1;
        exp_data       = '0;
        exp_wcnt       = 6'd0;
    endtask

    function automatic logic [127:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Setup helper: pushes n beats at full rate without comparing; the model still tracks them.
    task automatic run_beats(input int n);
        int target;
        target   = accepted + n;
        in_valid = 1'b1;
        in_data  = rand_beat();
        for (int c = 0; c < 4 * n + 200 && accepted < target; c++) begin
            tick();
            in_data = rand_beat();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_data !== 512'd0) begin
            errors++;
            $display("[TB] FAIL reset_out_data: got %h want 0", out_data);
        end
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got valid=%b done=%b want 0/0", out_valid, frame_done);
        end
        checks++;
        if (word_cnt !== 6'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_counts: got word_cnt=%0d ready=%b want 0/1", word_cnt, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_done || in_ready !== exp_ready ||
                word_cnt !== exp_wcnt || out_data !== exp_data) begin
                errors++;
                $display("[TB] FAIL reset_idle: got valid=%b done=%b ready=%b wcnt=%0d want %b %b %b %0d",
                         out_valid, frame_done, in_ready, word_cnt, exp_valid, exp_done, exp_ready, exp_wcnt);
            end
        end
    endtask

    task automatic test_packing();
        logic [127:0] b[4];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b[k] = {$urandom, $urandom, $urandom, 24'($urandom), 8'(8'hA0 + k)};
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = b[k];
            tick();
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_done || in_ready !== exp_ready ||
                word_cnt !== exp_wcnt || out_data !== exp_data) begin
                errors++;
                $display("[TB] FAIL packing_cycle: got valid=%b wcnt=%0d data=%h want %b %0d %h",
                         out_valid, word_cnt, out_data, exp_valid, exp_wcnt, exp_data);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {b[3], b[2], b[1], b[0]} || word_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL packing_word: got valid=%b wcnt=%0d data=%h want 1 1 %h",
                     out_valid, word_cnt, out_data, {b[3], b[2], b[1], b[0]});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== {b[3], b[2], b[1], b[0]}) begin
            errors++;
            $display("[TB] FAIL packing_hold: got valid=%b data=%h want 0 and held word", out_valid, out_data);
        end
    endtask

    task automatic test_full_frame();
        int beat_idx;
        int strobes;
        int dones;
        int ready_low;
        int last_accepted;
        do_reset();
        beat_idx  = 0;
        strobes   = 0;
        dones     = 0;
        ready_low = 0;
        in_valid  = 1'b1;
        in_data   = 128'(beat_idx);
        for (int c = 0; c < 256 + DRAIN + 10; c++) begin
            last_accepted = accepted;
            tick();
            if (accepted != last_accepted) beat_idx++;
            in_valid = (beat_idx < 256);
            in_data  = 128'(beat_idx);
            if (out_valid === 1'b1) strobes++;
            if (frame_done === 1'b1) dones++;
            if (in_ready === 1'b0) ready_low++;
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_done || in_ready !== exp_ready ||
                word_cnt !== exp_wcnt || out_data !== exp_data) begin
                errors++;
                $display("[TB] FAIL frame_cycle %0d: got valid=%b done=%b ready=%b wcnt=%0d want %b %b %b %0d",
                         c, out_valid, frame_done, in_ready, word_cnt, exp_valid, exp_done, exp_ready, exp_wcnt);
            end
        end
        checks++;
        if (strobes != WPF || dones != 1 || ready_low != DRAIN || word_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL frame_totals: got strobes=%0d dones=%0d ready_low=%0d wcnt=%0d want %0d 1 %0d 0",
                     strobes, dones, ready_low, word_cnt, WPF, DRAIN);
        end
    endtask

    task automatic test_stall_drain();
        logic [127:0] held;
        logic [127:0] b[3];
        int           stall_ticks;
        do_reset();
        run_beats(256);
        held        = rand_beat();
        in_valid    = 1'b1;
        in_data     = held;
        stall_ticks = 0;
        while (accepted < 257 && stall_ticks < 200) begin
            tick();
            stall_ticks++;
            checks++;
            if (in_ready !== exp_ready || out_valid !== exp_valid || word_cnt !== exp_wcnt) begin
                errors++;
                $display("[TB] FAIL stall_cycle: got ready=%b valid=%b wcnt=%0d want %b %b %0d",
                         in_ready, out_valid, word_cnt, exp_ready, exp_valid, exp_wcnt);
            end
        end
        checks++;
        if (stall_ticks != DRAIN + 1) begin
            errors++;
            $display("[TB] FAIL stall_length: got %0d cycles to first accept want %0d", stall_ticks, DRAIN + 1);
        end
        for (int k = 0; k < 3; k++) begin
            b[k]    = rand_beat();
            in_data = b[k];
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {b[2], b[1], b[0], held} || word_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL stall_word: got valid=%b wcnt=%0d data=%h want 1 1 %h",
                     out_valid, word_cnt, out_data, {b[2], b[1], b[0], held});
        end
    endtask

    task automatic test_gapped();
        int  strobes;
        int  last_accepted;
        logic prev_acc;
        do_reset();
        strobes  = 0;
        prev_acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid      = 1'($urandom_range(0, 1));
            in_data       = rand_beat();
            last_accepted = accepted;
            tick();
            if (out_valid === 1'b1) strobes++;
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_done || in_ready !== exp_ready ||
                word_cnt !== exp_wcnt || out_data !== exp_data) begin
                errors++;
                $display("[TB] FAIL gapped_cycle %0d: got valid=%b wcnt=%0d data=%h want %b %0d %h",
                         c, out_valid, word_cnt, out_data, exp_valid, exp_wcnt, exp_data);
            end
            prev_acc = (accepted != last_accepted);
            if (out_valid === 1'b1 && !prev_acc) begin
                checks++;
                errors++;
                $display("[TB] FAIL gapped_strobe: got out_valid=1 without an accepted beat want 0");
            end
        end
        in_valid = 1'b0;
        checks++;
        if (strobes != accepted / 4) begin
            errors++;
            $display("[TB] FAIL gapped_count: got %0d words want %0d", strobes, accepted / 4);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [127:0] b[4];
        do_reset();
        run_beats(2);
        RST = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || word_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL midword_async: got valid=%b ready=%b wcnt=%0d want 0 1 0", out_valid, in_ready, word_cnt);
        end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b[k]     = rand_beat();
            in_valid = 1'b1;
            in_data  = b[k];
            tick();
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_done || word_cnt !== exp_wcnt) begin
                errors++;
                $display("[TB] FAIL midword_cycle: got valid=%b done=%b wcnt=%0d want %b %b %0d",
                         out_valid, frame_done, word_cnt, exp_valid, exp_done, exp_wcnt);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {b[3], b[2], b[1], b[0]} || word_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL midword_word: got valid=%b wcnt=%0d data=%h want 1 1 %h",
                     out_valid, word_cnt, out_data, {b[3], b[2], b[1], b[0]});
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        run_beats(256);
        repeat (10) tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL middrain_stall: got ready=%b want 0", in_ready);
        end
        do_reset();
        checks++;
        if (in_ready !== 1'b1 || word_cnt !== 6'd0 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL middrain_reset: got ready=%b wcnt=%0d valid=%b done=%b want 1 0 0 0",
                     in_ready, word_cnt, out_valid, frame_done);
        end
        run_beats(4);
        checks++;
        if (out_valid !== 1'b1 || frame_done !== 1'b0 || word_cnt !== 6'd1 || out_data !== exp_data) begin
            errors++;
            $display("[TB] FAIL middrain_word: got valid=%b done=%b wcnt=%0d data=%h want 1 0 1 %h",
                     out_valid, frame_done, word_cnt, out_data, exp_data);
        end
    endtask

    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_packing();
        test_full_frame();
        test_stall_drain();
        test_gapped();
        test_reset_mid_word();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 65, number of cycles input is stalled after each complete frame (legal range 1..255).
REQ-002 Parameter WORDS_PER_FRAME, default 64, packed 512-bit words per frame (legal range 1..64).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  128  input beat payload.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 out_data  output  512  packed word to downstream SRAM stage.
REQ-009 out_valid  output  1  single-cycle strobe, out_data valid; no backpressure from downstream.
REQ-010 frame_done  output  1  single-cycle strobe coincident with last word of a frame.
REQ-011 word_cnt  output  6  index of next word to be emitted within current frame.

Function
REQ-012 Beat accepted exactly when in_valid && in_ready at a rising edge; no other beat is consumed.
REQ-013 Four accepted beats form one word: beat k (k=0..3, arrival order) placed in out_data[128k+127:128k].
REQ-014 Beat counter 2 bits, wraps 3->0 on the 4th accepted beat of a word.
REQ-015 Word emitted with latency 1: 4th beat accepted at edge N -> out_data updated and out_valid=1 during cycle after edge N, out_valid=0 next cycle unless another word completes.
REQ-016 out_data holds its last emitted value between strobes; partial beats collect in a separate staging register, never visible on out_data.
REQ-017 word_cnt increments with each out_valid; wraps to 0 after WORDS_PER_FRAME-1.
REQ-018 States: FILL (in_ready=1) and DRAIN (in_ready=0); in_ready is decoded from registered state only, never from in_valid.
REQ-019 FILL -> DRAIN on the edge accepting the last beat of word WORDS_PER_FRAME-1; frame_done=1 in the same cycle as that word's out_valid.
REQ-020 DRAIN lasts exactly DRAIN_CYCLES cycles, counted by an 8-bit down-counter loaded on entry; DRAIN -> FILL when counter reaches 1.
REQ-021 Default DRAIN_CYCLES covers downstream busy window (1 transfer cycle + 64 send cycles) so no word is ever issued while downstream is not receiving.
REQ-022 in_valid asserted during DRAIN ignored; in_data not sampled; beat remains pending at source.
REQ-023 Gaps in in_valid during FILL allowed at any beat position; partial word and counters held unchanged.
REQ-024 Back-to-back full-rate input: one word every 4 cycles; frame of 64 words in 256 accepted cycles.

Reset
REQ-025 RST asserted: state=FILL, beat counter=0, word_cnt=0, drain counter=0, staging register=0, out_data=0, out_valid=0, frame_done=0, in_ready=1 after release.
REQ-026 RST mid-word or mid-DRAIN discards partial beats and pending drain; no out_valid or frame_done produced by the discarded data.
REQ-027 No output strobe in the cycle RST deasserts.

Verification
REQ-028 Reset: RST pulse -> out_data=0, out_valid=0, frame_done=0, word_cnt=0, in_ready=1.
REQ-029 Packing: beats 0x...A0,0x...A1,0x...A2,0x...A3 at full rate -> one out_valid, out_data={A3,A2,A1,A0}, word_cnt 0->1.
REQ-030 Full frame: 256 consecutive beats (beat i = i) -> 64 out_valid strobes every 4 cycles, frame_done only on 64th, in_ready=0 exactly 65 cycles starting cycle after 256th beat accepted, word_cnt back to 0.
REQ-031 Stall during DRAIN: in_valid held high through DRAIN -> zero beats consumed, first beat accepted on first FILL cycle, next word value matches held in_data.
REQ-032 Gapped input: in_valid random 50% duty -> words identical to full-rate case, out_valid never adjacent to a missing beat.
REQ-033 Reset mid-word: 2 beats then RST, then 4 new beats B0..B3 -> single word {B3,B2,B1,B0}, word_cnt=1.
